mem_stage_lsu: RTL

- Parametrised memory-access pipeline stage between EX and WB.
- Accepts one instruction per handshake and waits for the data-memory response (data_ok/rdata) when the instruction issued a load request.
- Aligns and sign/zero-extends load data, and holds response data in a one-entry buffer while WB stalls.
- Discards responses belonging to flushed loads; drives a bypass bus for hazard resolution in earlier stages.

---
 rtl/mem_stage_lsu.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage between EX and WB.
//
// Holds one instruction. For loads that issued a data request it waits for
// the data-memory response, aligns and sign/zero-extends the returned word,
// and keeps the response in a one-entry buffer while WB is stalled.
// Responses that belong to flushed loads are counted and dropped.
//
// Optional feature macro: MEM_LOAD_BYPASS_EN
//   defined   : load data is forwarded on the bypass bus in the cycle it
//               arrives, so byp_pending drops as soon as data is usable.
//   undefined : byp_pending stays high while a requesting load sits in MEM;
//               consumers wait until it has moved on to WB.
//
// Handshake: both sides use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high; valid never depends on
// the downstream ready of the same interface, and a flush cancels any
// transfer in its cycle (no capture, no handoff).
//
// Debug outputs dbg_discard_cnt / dbg_buf_valid expose internal state for
// checkers and waveform inspection; they have no functional role.

module mem_stage_lsu #(
  parameter int XLEN            = 32,  // 32 or 64
  parameter int RF_AW           = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // EX -> MEM
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [XLEN-1:0]                      in_pc,
  input  logic [XLEN-1:0]                      in_alu_result,
  input  logic                                 in_rf_we,
  input  logic [RF_AW-1:0]                     in_rf_waddr,
  input  logic [2:0]                           in_ld_op,
  input  logic                                 in_req_sent,
  // data-memory response
  input  logic                                 data_ok,
  input  logic [XLEN-1:0]                      data_rdata,
  // pipeline kill
  input  logic                                 flush,
  // MEM -> WB
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [XLEN-1:0]                      out_pc,
  output logic                                 out_rf_we,
  output logic [RF_AW-1:0]                     out_rf_waddr,
  output logic [XLEN-1:0]                      out_wdata,
  // bypass bus towards earlier stages
  output logic                                 byp_we,
  output logic [RF_AW-1:0]                     byp_waddr,
  output logic [XLEN-1:0]                      byp_wdata,
  output logic                                 byp_pending,
  // debug visibility of internal state
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_discard_cnt,
  output logic                                 dbg_buf_valid
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  // load operation encodings; 5..7 all behave as a full word load
  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_BU   = 3'd2;
  localparam logic [2:0] LD_H    = 3'd3;
  localparam logic [2:0] LD_HU   = 3'd4;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              valid_q,       valid_d;
  logic [XLEN-1:0]   pc_q,          pc_d;
  logic [XLEN-1:0]   alu_q,         alu_d;
  logic              rf_we_q,       rf_we_d;
  logic [RF_AW-1:0]  rf_waddr_q,    rf_waddr_d;
  logic [2:0]        ld_op_q,       ld_op_d;
  logic              need_data_q,   need_data_d;
  logic              buf_valid_q,   buf_valid_d;
  logic [31:0]       buf_data_q,    buf_data_d;
  logic [CW-1:0]     discard_cnt_q, discard_cnt_d;

  // ---------------------------------------------------------------------
  // Control signals
  // ---------------------------------------------------------------------
  logic got_data;     // response this cycle belongs to the held load
  logic ready_go;     // held entry has everything it needs to leave
  logic accept;       // EX -> MEM transfer this cycle
  logic handoff;      // MEM -> WB transfer this cycle
  logic discard_inc;  // flushed load will still receive a response
  logic discard_dec;  // a response for an earlier flushed load arrived

  // Handshake and response-ownership decisions for the current cycle.
  always_comb begin
    got_data    = data_ok & (discard_cnt_q == '0);
    ready_go    = ~need_data_q | buf_valid_q | got_data;
    in_ready    = (~valid_q | (ready_go & out_ready)) & (discard_cnt_q < MAX_CNT);
    out_valid   = valid_q & ready_go & ~flush;
    accept      = in_valid & in_ready & ~flush;
    handoff     = out_valid & out_ready;
    // A response already buffered or arriving right now needs no discard.
    discard_inc = flush & valid_q & need_data_q & ~buf_valid_q & ~got_data;
    discard_dec = data_ok & (discard_cnt_q != '0);
  end

  // ---------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------
  logic [31:0]     ld_word;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // Pick the buffered or live word, then select and extend the addressed lane.
  always_comb begin
    ld_word = buf_valid_q ? buf_data_q : data_rdata[31:0];
    ld_byte = ld_word[{alu_q[1:0], 3'b000} +: 8];
    ld_half = alu_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_op_q)
      LD_B:    ld_ext = XLEN'($signed(ld_byte));
      LD_BU:   ld_ext = XLEN'(ld_byte);
      LD_H:    ld_ext = XLEN'($signed(ld_half));
      LD_HU:   ld_ext = XLEN'(ld_half);
      default: ld_ext = XLEN'($signed(ld_word));
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // Entry capture/release, response buffering and the discard counter.
  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    alu_d         = alu_q;
    rf_we_d       = rf_we_q;
    rf_waddr_d    = rf_waddr_q;
    ld_op_d       = ld_op_q;
    need_data_d   = need_data_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    discard_cnt_d = discard_cnt_q;

    if (flush) begin
      // Flush wins over any capture and drops the held entry.
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      pc_d        = in_pc;
      alu_d       = in_alu_result;
      rf_we_d     = in_rf_we;
      rf_waddr_d  = in_rf_waddr;
      ld_op_d     = in_ld_op;
      need_data_d = (in_ld_op != LD_NONE) & in_req_sent;
      buf_valid_d = 1'b0;
    end else if (handoff) begin
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (valid_q & need_data_q & ~buf_valid_q & got_data & ~out_ready) begin
      // WB is stalled: keep the response so the memory need not hold it.
      buf_valid_d = 1'b1;
      buf_data_d  = data_rdata[31:0];
    end

    // Simultaneous increment and decrement cancel out.
    case ({discard_inc, discard_dec})
      2'b10:   discard_cnt_d = discard_cnt_q + CW'(1);
      2'b01:   discard_cnt_d = discard_cnt_q - CW'(1);
      default: discard_cnt_d = discard_cnt_q;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      alu_q         <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      ld_op_q       <= LD_NONE;
      need_data_q   <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= '0;
      discard_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      alu_q         <= alu_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      ld_op_q       <= ld_op_d;
      need_data_q   <= need_data_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // WB result, bypass bus and debug visibility.
  always_comb begin
    out_pc          = pc_q;
    out_rf_we       = out_valid & rf_we_q;
    out_rf_waddr    = rf_waddr_q;
    out_wdata       = (ld_op_q != LD_NONE) ? ld_ext : alu_q;
    byp_we          = valid_q & rf_we_q;
    byp_waddr       = rf_waddr_q;
    byp_wdata       = out_wdata;
`ifdef MEM_LOAD_BYPASS_EN
    byp_pending     = valid_q & need_data_q & ~buf_valid_q & ~got_data;
`else
    byp_pending     = valid_q & need_data_q;
`endif
    dbg_discard_cnt = discard_cnt_q;
    dbg_buf_valid   = buf_valid_q;
  end

endmodule
